pipelined_adder: RTL

Parametrised, pipelined N-bit add/subtract unit with a valid/ready handshake and RISC-V-style result flags. It is the multi-cycle successor to the single-cycle ripple adder. The carry chain is split into STAGES registered slices, so wide operands close timing at high clock rates. It sits between the execute-stage operand muxes and the writeback/branch-compare logic, and also serves as the adder inside the multi-cycle M-extension datapath.

---
 rtl/pipelined_adder_pkg.sv | 32 +++
 rtl/add_slice.sv | 27 ++
 rtl/pipelined_adder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit and its consumers
// (writeback, branch comparator).
//   add_op_e    : encoding of the 'sub' input (ADD / SUB).
//   add_flags_t : result flag bundle, bit order {cout, ovf, zero}, shared
//                 with the branch comparator.
//   make_flags  : builds the flag bundle from the final carries and zero test.
package pipelined_adder_pkg;

  typedef enum logic {
    ADD_OP_ADD = 1'b0,
    ADD_OP_SUB = 1'b1
  } add_op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } add_flags_t;

  // carry_msb is the carry into the top bit; signed overflow is when it
  // disagrees with the carry out of the top bit.
  function automatic add_flags_t make_flags(input logic carry,
                                            input logic carry_msb,
                                            input logic sum_is_zero);
    add_flags_t f;
    f.cout = carry;
    f.ovf  = carry ^ carry_msb;
    f.zero = sum_is_zero;
    return f;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit adder slice, one per pipeline stage.
//   x, y  : slice operands (y already inverted for subtraction)
//   cin   : carry into bit 0 of the slice
//   s     : slice sum
//   cout  : carry out of bit W-1
//   c_msb : carry into bit W-1 (used for signed overflow on the top slice)
module add_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  assign s     = full[W-1:0];
  assign cout  = full[W];
  // Sum bit = x ^ y ^ carry_in, so the carry into the top bit falls out
  // of the top sum bit without a second adder.
  assign c_msb = x[W-1] ^ y[W-1] ^ s[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit with valid/ready handshake and
// {cout, ovf, zero} result flags. The carry chain is cut into STAGES
// registered slices of W = N/STAGES bits; latency is STAGES cycles.
//   clk, rst              : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready = !out_valid || out_ready)
//   a, b, sub             : operands; sub=1 computes a - b
//   out_valid / out_ready : result handshake
//   sum, cout, ovf, zero  : result and flags (cout=1 on sub means no borrow)
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned W = N / STAGES;

  add_op_e    op;
  logic       adv;
  logic [N-1:0] b_eff;
  logic       c0;
  add_flags_t flags;

  assign op       = add_op_e'(sub);
  // Whole pipeline advances or holds as one; bubbles are never collapsed.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (op == ADD_OP_SUB) ? ~b : b;
  assign c0       = (op == ADD_OP_SUB);

  // Stage k adds slice k. It carries forward the completed low sum slices
  // and only the operand bits above slice k, so register widths taper.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * W;
    localparam int unsigned HI = LO + W - 1;

    logic [N-1:LO] a_in;
    logic [N-1:LO] b_in;
    logic          cin;
    logic          valid_d;
    logic [HI:0]   sum_d;
    logic [W-1:0]  s;
    logic          c_out;
    logic          c_msb;
    logic          valid_q;
    logic          carry_q;
    logic [HI:0]   sum_q;

    if (k == 0) begin : g_src
      assign a_in    = a;
      assign b_in    = b_eff;
      assign cin     = c0;
      assign valid_d = in_valid;
      assign sum_d   = s;
    end else begin : g_src
      assign a_in    = g_stage[k-1].g_ops.a_q;
      assign b_in    = g_stage[k-1].g_ops.b_q;
      assign cin     = g_stage[k-1].carry_q;
      assign valid_d = g_stage[k-1].valid_q;
      assign sum_d   = {s, g_stage[k-1].sum_q};
    end

    add_slice #(.W(W)) u_slice (
      .x     (a_in[HI:LO]),
      .y     (b_in[HI:LO]),
      .cin   (cin),
      .s     (s),
      .cout  (c_out),
      .c_msb (c_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        carry_q <= c_out;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [N-1:HI+1] a_q;
      logic [N-1:HI+1] b_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[N-1:HI+1];
          b_q <= b_in[N-1:HI+1];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic msb_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          msb_q <= 1'b0;
        end else if (adv) begin
          msb_q <= c_msb;
        end
      end
    end else begin : g_mid
      // Only the top slice needs the carry into its MSB.
      logic unused_c_msb;
      assign unused_c_msb = c_msb;
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign flags     = make_flags(g_stage[STAGES-1].carry_q,
                                g_stage[STAGES-1].g_last.msb_q,
                                sum == '0);
  assign cout      = flags.cout;
  assign ovf       = flags.ovf;
  assign zero      = flags.zero;

endmodule
